// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-index/mask types and the index-to-mask helper.
package reg_scoreboard_pkg;
  localparam int SB_NREG = 31;
  typedef logic [4:0] regidx_t;
  typedef logic [SB_NREG-1:0] regmask_t;
  // GPR k maps to mask bit k-1; r0 has no bit
  function automatic regmask_t onehot(regidx_t k);
    return (k == 5'd0) ? '0 : regmask_t'(1) << (k - 5'd1);
  endfunction
endpackage

// File: rtl/reg_scoreboard_sb_cell.sv
// sb_cell: in-flight write counter for one register with busy/full/underflow flags.
module sb_cell #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic busy_o,
  output logic full_o,
  output logic underflow_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign busy_o = |cnt_q;
  assign full_o = &cnt_q;
  // a simultaneous inc and dec cancel, so an empty counter hit by both is not an underflow
  assign underflow_o = dec_i && !inc_i && !clr_i && !busy_o;
  always_comb
    cnt_d = clr_i ? '0 :
            (inc_i && !dec_i && !full_o) ? cnt_q + 1'b1 :
            (dec_i && !inc_i && busy_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracking, issue hazard gating and stall counting.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = SB_NREG,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  input  logic [NREG-1:0]    rmask,
  input  logic [NREG-1:0]    wmask,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  regidx_t            wb_reg,
  input  logic               flush,
  output logic [NREG-1:0]    busy_mask,
  output logic [STALL_W-1:0] stall_count,
  output logic               err_underflow
);
  logic [NREG-1:0] full, uf, wb_dec;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic err_q, fire;
  assign wb_dec = wb_valid ? NREG'(onehot(wb_reg)) : '0;
  // hazards use registered counters only; a same-cycle writeback does not unblock a reader
  assign issue_ready = !flush && ((rmask & busy_mask) == '0) && ((wmask & full) == '0);
  assign fire = issue_valid && issue_ready;
  for (genvar g = 0; g < NREG; g++) begin : g_cell
    sb_cell #(.CNT_W(CNT_W)) u_cell (
      .clk        (clk),
      .resetn     (resetn),
      .inc_i      (fire && wmask[g]),
      .dec_i      (wb_dec[g] && !flush),
      .clr_i      (flush),
      .busy_o     (busy_mask[g]),
      .full_o     (full[g]),
      .underflow_o(uf[g])
    );
  end
  always_comb
    stall_d = (issue_valid && !issue_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_q | (|uf);
    end
  assign stall_count   = stall_q;
  assign err_underflow = err_q;
endmodule
